stats_collector_multi: RTL and testbench

- Parametrised per-PHY traffic statistics engine that sits after packet-attribute extraction in the monitoring output-port-lookup pcore.
- Accumulates per-port packet, byte, VLAN, IP, TCP and UDP counts of configurable width, plus a count of packets from unknown sources.
- Holds a freezable snapshot with a timestamp.
- Software reads the snapshot through an indexed 32-bit read port instead of flat counter outputs.

---
 rtl/stats_collector_multi.sv | 195 +++++++++++++++++++
 tb/tb_stats_collector_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stats_collector_multi.sv
// Per-PHY traffic statistics engine: live counters, freezable snapshot, indexed 32-bit read port.
// Optional macro STATS_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module stats_collector_multi #(
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int TIMESTAMP_WIDTH      = 64,
   parameter int ATTRIBUTE_DATA_WIDTH = 135,
   parameter int NUM_PHY              = 4,
   parameter int NUM_INPUT_QUEUES     = 8,
   parameter int TUPLE_WIDTH          = 104,
   parameter int BYTES_COUNT_WIDTH    = 16,
   parameter int COUNTER_WIDTH        = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ATTRIBUTE_DATA_WIDTH-1:0] pkt_attributes,
   input  logic                            pkt_valid,
   input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
   input  logic                            stats_freeze,
   input  logic                            rst_stats,
   input  logic                            rd_req,
   input  logic [7:0]                      rd_addr,
   output logic                            rd_valid,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data,
   output logic                            rd_err
);

   localparam int CW = COUNTER_WIDTH;
   localparam int F  = TUPLE_WIDTH + BYTES_COUNT_WIDTH;
   localparam int PW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;

   function automatic logic [CW-1:0] acc(input logic [CW-1:0] a, input logic [CW-1:0] b);
`ifdef STATS_SATURATE_EN
      logic [CW:0] s;
      s = {1'b0, a} + {1'b0, b};
      acc = s[CW] ? '1 : s[CW-1:0];
`else
      acc = a + b;
`endif
   endfunction

   logic [NUM_INPUT_QUEUES-1:0] src_p0;
   logic [NUM_INPUT_QUEUES-1:0] onehot;
   logic [PW-1:0]               port_p0;
   logic                        known_p0;
   logic                        unused_attr;

   assign src_p0      = pkt_attributes[ATTRIBUTE_DATA_WIDTH-1 -: NUM_INPUT_QUEUES];
   assign unused_attr = ^pkt_attributes;

   // Only an exact single bit at an even position 2*i maps to a counted port.
   always_comb begin
      port_p0  = '0;
      known_p0 = 1'b0;
      for (int i = 0; i < NUM_PHY; i++) begin
         onehot        = '0;
         onehot[2*i]   = 1'b1;
         if (src_p0 == onehot) begin
            port_p0  = PW'(i);
            known_p0 = 1'b1;
         end
      end
      onehot = '0;
   end

   // ---- stage 1: input register ----
   logic          vld_p1;
   logic [PW-1:0] port_p1;
   logic [CW-1:0] bytes_p1;
   logic          known_p1, ip_p1, tcp_p1, udp_p1, vlan_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= pkt_valid && !rst_stats;
   end

   always_ff @(posedge clk) begin
      if (pkt_valid) begin
         port_p1  <= port_p0;
         known_p1 <= known_p0;
         bytes_p1 <= CW'(pkt_attributes[F-1 -: BYTES_COUNT_WIDTH]);
         ip_p1    <= pkt_attributes[F];
         tcp_p1   <= pkt_attributes[F+1];
         udp_p1   <= pkt_attributes[F+2];
         vlan_p1  <= pkt_attributes[F+3] | pkt_attributes[F+4];
      end
   end

   // ---- stage 2: accumulate ----
   logic [CW-1:0] live [NUM_PHY][6];
   logic [CW-1:0] unk_cnt;

   for (genvar g = 0; g < NUM_PHY; g++) begin : g_port
      logic [CW-1:0] pkt_cnt, byte_cnt, vlan_cnt, ip_cnt, tcp_cnt, udp_cnt;
      logic          hit;
      assign hit = vld_p1 && known_p1 && (port_p1 == PW'(g));

      always_ff @(posedge clk or posedge reset) begin
         if (reset || rst_stats) begin
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            vlan_cnt <= '0;
            ip_cnt   <= '0;
            tcp_cnt  <= '0;
            udp_cnt  <= '0;
         end else if (hit) begin
            pkt_cnt  <= acc(pkt_cnt,  CW'(1));
            byte_cnt <= acc(byte_cnt, bytes_p1);
            vlan_cnt <= acc(vlan_cnt, CW'(vlan_p1));
            ip_cnt   <= acc(ip_cnt,   CW'(ip_p1));
            tcp_cnt  <= acc(tcp_cnt,  CW'(tcp_p1));
            udp_cnt  <= acc(udp_cnt,  CW'(udp_p1));
         end
      end

      assign live[g][0] = pkt_cnt;
      assign live[g][1] = byte_cnt;
      assign live[g][2] = vlan_cnt;
      assign live[g][3] = ip_cnt;
      assign live[g][4] = tcp_cnt;
      assign live[g][5] = udp_cnt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset || rst_stats)         unk_cnt <= '0;
      else if (vld_p1 && !known_p1)   unk_cnt <= acc(unk_cnt, CW'(1));
   end

   // ---- snapshot ----
   logic [CW-1:0]              snap [NUM_PHY][6];
   logic [CW-1:0]              unk_snap;
   logic [TIMESTAMP_WIDTH-1:0] snap_time;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PHY; p++)
            for (int k = 0; k < 6; k++)
               snap[p][k] <= '0;
         unk_snap  <= '0;
         snap_time <= '0;
      end else if (!stats_freeze) begin
         for (int p = 0; p < NUM_PHY; p++)
            for (int k = 0; k < 6; k++)
               snap[p][k] <= live[p][k];
         unk_snap  <= unk_cnt;
         snap_time <= stamp_counter;
      end
   end

   // ---- read decode and response register ----
   logic [3:0]  port_a;
   logic [2:0]  cnt_a;
   logic [63:0] sel;
   logic        err;
   logic [31:0] word;

   assign port_a = rd_addr[7:4];
   assign cnt_a  = rd_addr[3:1];

   always_comb begin
      sel = '0;
      err = 1'b1;
      if (port_a == 4'hF) begin
         if (cnt_a == 3'd0) begin
            sel = 64'(snap_time);
            err = 1'b0;
         end else if (cnt_a == 3'd1) begin
            sel = 64'(unk_snap);
            err = 1'b0;
         end
      end else begin
         for (int p = 0; p < NUM_PHY; p++)
            for (int k = 0; k < 6; k++)
               if (port_a == 4'(p) && cnt_a == 3'(k)) begin
                  sel = 64'(snap[p][k]);
                  err = 1'b0;
               end
      end
      word = rd_addr[0] ? sel[63:32] : sel[31:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_data <= word;
            rd_err  <= err;
         end
      end
   end

endmodule

// File: tb/tb_stats_collector_multi.sv
// Directed self-checking bench for stats_collector_multi (default parameters).
module tb_stats_collector_multi;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [134:0] pkt_attributes = '0;
   logic         pkt_valid = 1'b0;
   logic [63:0]  stamp_counter = 64'h0000_0001_0000_0010;
   logic         stats_freeze = 1'b0;
   logic         rst_stats = 1'b0;
   logic         rd_req = 1'b0;
   logic [7:0]   rd_addr = '0;
   logic         rd_valid;
   logic [31:0]  rd_data;
   logic         rd_err;

   int vectors = 0;
   int errors  = 0;

   stats_collector_multi dut (
      .clk(clk), .reset(reset), .pkt_attributes(pkt_attributes), .pkt_valid(pkt_valid),
      .stamp_counter(stamp_counter), .stats_freeze(stats_freeze), .rst_stats(rst_stats),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // flags: bit0 IP, bit1 TCP, bit2 UDP, bit3 VLAN_Q, bit4 VLAN_AD
   task automatic send_pkt(input logic [7:0] src, input logic [15:0] b, input logic [4:0] fl);
      logic [134:0] a;
      @(negedge clk);
      a = '0;
      a[134:127] = src;
      a[119:104] = b;
      a[124:120] = fl;
      pkt_attributes = a;
      pkt_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      pkt_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                          input logic exp_e);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = a;
      @(posedge clk);
      #1;
      check({tag, ".valid"}, 64'(rd_valid), 64'd1);
      check({tag, ".data"}, 64'(rd_data), 64'(exp_d));
      check({tag, ".err"}, 64'(rd_err), 64'(exp_e));
      @(negedge clk);
      rd_req = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".drop"}, 64'(rd_valid), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid", 64'(rd_valid), 64'd0);
      check("rst.data", 64'(rd_data), 64'd0);
      check("rst.err", 64'(rd_err), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      do_read("p0pkt0", 8'h00, 32'd0, 1'b0);

      // Back-to-back packets on port 1 plus one on port 2
      send_pkt(8'h04, 16'd64, 5'b00011);
      send_pkt(8'h04, 16'd128, 5'b00011);
      send_pkt(8'h04, 16'd1500, 5'b00011);
      send_pkt(8'h10, 16'd100, 5'b10100);
      idle(3);
      do_read("p1pkt", 8'h10, 32'd3, 1'b0);
      do_read("p1bytes", 8'h12, 32'd1692, 1'b0);
      do_read("p1bytesh", 8'h13, 32'd0, 1'b0);
      do_read("p1vlan", 8'h14, 32'd0, 1'b0);
      do_read("p1ip", 8'h16, 32'd3, 1'b0);
      do_read("p1tcp", 8'h18, 32'd3, 1'b0);
      do_read("p1udp", 8'h1A, 32'd0, 1'b0);
      do_read("p2bytes", 8'h22, 32'd100, 1'b0);
      do_read("p2vlan", 8'h24, 32'd1, 1'b0);
      do_read("p2udp", 8'h2A, 32'd1, 1'b0);
      do_read("p0bytes", 8'h02, 32'd0, 1'b0);

      // Unknown sources
      send_pkt(8'h03, 16'd50, 5'b00001);
      send_pkt(8'h00, 16'd50, 5'b00001);
      idle(3);
      do_read("unk", 8'hF2, 32'd2, 1'b0);
      do_read("unk.p0", 8'h00, 32'd0, 1'b0);
      do_read("unk.p1", 8'h10, 32'd3, 1'b0);

      // Freeze holds the snapshot while port 0 counts underneath
      @(negedge clk);
      stats_freeze = 1'b1;
      repeat (5) send_pkt(8'h01, 16'd10, 5'b00000);
      idle(3);
      do_read("frz.p0", 8'h00, 32'd0, 1'b0);
      do_read("frz.tl", 8'hF0, 32'h0000_0010, 1'b0);
      do_read("frz.th", 8'hF1, 32'h0000_0001, 1'b0);
      @(negedge clk);
      stamp_counter = 64'h0000_0ABC_DEAD_BEEF;
      stats_freeze = 1'b0;
      @(negedge clk);
      stats_freeze = 1'b1;
      stamp_counter = 64'h0000_0ABC_DEAD_C0DE;
      do_read("rel.p0", 8'h00, 32'd5, 1'b0);
      do_read("rel.b0", 8'h02, 32'd50, 1'b0);
      do_read("rel.tl", 8'hF0, 32'hDEAD_BEEF, 1'b0);
      do_read("rel.th", 8'hF1, 32'h0000_0ABC, 1'b0);
      @(negedge clk);
      stats_freeze = 1'b0;

      // rst_stats coinciding with an accumulate
      send_pkt(8'h40, 16'd20, 5'b00001);
      @(negedge clk);
      pkt_valid = 1'b0;
      rst_stats = 1'b1;
      @(negedge clk);
      rst_stats = 1'b0;
      repeat (3) @(posedge clk);
      do_read("clr.p3", 8'h30, 32'd0, 1'b0);
      do_read("clr.p1", 8'h10, 32'd0, 1'b0);
      do_read("clr.unk", 8'hF2, 32'd0, 1'b0);

      // rst_stats together with pkt_valid flushes stage 1
      send_pkt(8'h40, 16'd20, 5'b00001);
      rst_stats = 1'b1;
      @(negedge clk);
      pkt_valid = 1'b0;
      rst_stats = 1'b0;
      repeat (3) @(posedge clk);
      do_read("flush.p3", 8'h30, 32'd0, 1'b0);
      send_pkt(8'h40, 16'd20, 5'b00001);
      idle(3);
      do_read("after.p3", 8'h30, 32'd1, 1'b0);
      do_read("after.ip3", 8'h36, 32'd1, 1'b0);

      // Overflow at the top of the port-0 packet counter
      @(negedge clk);
      force dut.g_port[0].pkt_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.g_port[0].pkt_cnt;
      repeat (2) @(posedge clk);
      do_read("pre.p0h", 8'h01, 32'hFFFF_FFFF, 1'b0);
      send_pkt(8'h01, 16'd1, 5'b00000);
      idle(3);
`ifdef STATS_SATURATE_EN
      do_read("ovf.p0l", 8'h00, 32'hFFFF_FFFF, 1'b0);
      do_read("ovf.p0h", 8'h01, 32'hFFFF_FFFF, 1'b0);
`else
      do_read("ovf.p0l", 8'h00, 32'd0, 1'b0);
      do_read("ovf.p0h", 8'h01, 32'd0, 1'b0);
`endif

      // Decode errors
      do_read("err.5C", 8'h5C, 32'd0, 1'b1);
      do_read("err.0E", 8'h0E, 32'd0, 1'b1);
      do_read("err.F4", 8'hF4, 32'd0, 1'b1);

      // Two consecutive requests, one response each
      @(negedge clk);
      rd_req = 1'b1;
      rd_addr = 8'h30;
      @(posedge clk);
      #1;
      check("b2b.v0", 64'(rd_valid), 64'd1);
      check("b2b.d0", 64'(rd_data), 64'd1);
      @(negedge clk);
      rd_addr = 8'h5C;
      @(posedge clk);
      #1;
      check("b2b.v1", 64'(rd_valid), 64'd1);
      check("b2b.e1", 64'(rd_err), 64'd1);
      check("b2b.d1", 64'(rd_data), 64'd0);
      @(negedge clk);
      rd_req = 1'b0;

      // Reset while a response is pending
      @(negedge clk);
      rd_req = 1'b1;
      rd_addr = 8'h30;
      @(posedge clk);
      #1;
      check("mid.v", 64'(rd_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid.drop", 64'(rd_valid), 64'd0);
      check("mid.data", 64'(rd_data), 64'd0);
      @(negedge clk);
      rd_req = 1'b0;
      reset = 1'b0;
      do_read("post.p3", 8'h30, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
